// File: rtl/cmul_pkg.sv
// Shared types and constants for the complex-multiply sequencer.
package cmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } hs_state_e;

    localparam logic [1:0] IDX_RR = 2'd0;
    localparam logic [1:0] IDX_II = 2'd1;
    localparam logic [1:0] IDX_RI = 2'd2;
    localparam logic [1:0] IDX_IR = 2'd3;

    localparam int FP_SIGN_W = 1;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MAN_W  = 23;
    localparam int FP_W      = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

endpackage

// File: rtl/cmul_hs_port.sv
// Handshake engine for one multiplier request at a time: mul_str level, GAP spacing,
// and a REQ watchdog that exists only when CMUL_SEQUENCER_TIMEOUT_EN is defined.
module cmul_hs_port
    import cmul_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       last,
    input  logic       mul_done,
    output logic       mul_str,
    output logic       capture,
    output logic       advance,
    output logic       timeout,
    output logic       finish,
    output logic [1:0] state
);

    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    hs_state_e        state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             mul_str_q, mul_str_d;

`ifdef CMUL_SEQUENCER_TIMEOUT_EN
    localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // Counts consecutive REQ cycles; restarts on every fresh entry into REQ.
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == ST_REQ && state_d == ST_REQ) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        capture   = 1'b0;
        advance   = 1'b0;
        timeout   = 1'b0;
        finish    = (state_q == ST_FIN);
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mul_done) begin
                    capture   = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
`ifdef CMUL_SEQUENCER_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_FIN;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (last) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_REQ;
                        advance = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered from the next state so the strobe is glitch-free and exactly tracks REQ.
    always_comb mul_str_d = (state_d == ST_REQ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            mul_str_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            mul_str_q <= mul_str_d;
        end
    end

    assign mul_str = mul_str_q;
    assign state   = state_q;

endmodule

// File: rtl/cmul_sequencer.sv
// Sequences the four real products of a complex multiply through one shared FP multiplier.
// Optional REQ watchdog is enabled by defining CMUL_SEQUENCER_TIMEOUT_EN.
module cmul_sequencer
    import cmul_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [FP_W-1:0] a_re,
    input  logic [FP_W-1:0] a_im,
    input  logic [FP_W-1:0] w_re,
    input  logic [FP_W-1:0] w_im,
    output logic [FP_W-1:0] p_rr,
    output logic [FP_W-1:0] p_ii,
    output logic [FP_W-1:0] p_ri,
    output logic [FP_W-1:0] p_ir,
    output logic            err,
    output logic            mul_str,
    output logic [FP_W-1:0] mul_a,
    output logic [FP_W-1:0] mul_b,
    input  logic [FP_W-1:0] mul_result,
    input  logic            mul_done,
    input  logic            mul_error
);

    logic [FP_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic [FP_W-1:0] w_re_q, w_re_d, w_im_q, w_im_d;
    logic [FP_W-1:0] p_q [4];
    logic [FP_W-1:0] p_d [4];
    logic [1:0]      idx_q, idx_d;
    logic            err_q, err_d, busy_q, busy_d, done_q, done_d;

    logic [1:0] hs_state;
    logic       accept, capture, advance, timeout, finish;

    // Only IDLE accepts start, which is what makes start a no-op while busy.
    assign accept = start && (hs_state == ST_IDLE);

    cmul_hs_port #(
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hs_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (accept),
        .last     (idx_q == IDX_IR),
        .mul_done (mul_done),
        .mul_str  (mul_str),
        .capture  (capture),
        .advance  (advance),
        .timeout  (timeout),
        .finish   (finish),
        .state    (hs_state)
    );

    always_comb begin
        a_re_d = a_re_q;
        a_im_d = a_im_q;
        w_re_d = w_re_q;
        w_im_d = w_im_q;
        p_d    = p_q;
        idx_d  = idx_q;
        err_d  = err_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (accept) begin
            a_re_d = a_re;
            a_im_d = a_im;
            w_re_d = w_re;
            w_im_d = w_im;
            for (int i = 0; i < 4; i++) begin
                p_d[i] = '0;
            end
            idx_d  = IDX_RR;
            err_d  = 1'b0;
            busy_d = 1'b1;
        end
        if (capture) begin
            p_d[idx_q] = mul_result;
            err_d      = err_q | mul_error;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
        if (advance) begin
            idx_d = idx_q + 2'd1;
        end
        if (finish) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    // Operand pair for each product index, in p_rr, p_ii, p_ri, p_ir order.
    always_comb begin
        mul_a = a_re_q;
        mul_b = w_re_q;
        case (idx_q)
            IDX_II: begin mul_a = a_im_q; mul_b = w_im_q; end
            IDX_RI: begin mul_a = a_re_q; mul_b = w_im_q; end
            IDX_IR: begin mul_a = a_im_q; mul_b = w_re_q; end
            default: begin mul_a = a_re_q; mul_b = w_re_q; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_re_q <= '0;
            a_im_q <= '0;
            w_re_q <= '0;
            w_im_q <= '0;
            for (int i = 0; i < 4; i++) begin
                p_q[i] <= '0;
            end
            idx_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_re_q <= a_re_d;
            a_im_q <= a_im_d;
            w_re_q <= w_re_d;
            w_im_q <= w_im_d;
            p_q    <= p_d;
            idx_q  <= idx_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign p_rr = p_q[IDX_RR];
    assign p_ii = p_q[IDX_II];
    assign p_ri = p_q[IDX_RI];
    assign p_ir = p_q[IDX_IR];
    assign err  = err_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_cmul_sequencer.sv
// Directed bench for cmul_sequencer with a D=7 table-driven multiplier responder.
// The timeout scenario runs only when CMUL_SEQUENCER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_cmul_sequencer;

    localparam int RESP_D = 7;
    localparam int GAP    = 4;
    localparam int TMO    = 64;
    localparam int LAT    = 1 + 4 * (RESP_D + GAP) + 1;

    // Vector 1: a = 1 + j2, w = 0.5 - j1
    localparam logic [31:0] V1_AR = 32'h3F800000, V1_AI = 32'h40000000;
    localparam logic [31:0] V1_WR = 32'h3F000000, V1_WI = 32'hBF800000;
    localparam logic [31:0] V1_RR = 32'h3F000000, V1_II = 32'hC0000000;
    localparam logic [31:0] V1_RI = 32'hBF800000, V1_IR = 32'h3F800000;
    // Vector 2: a = 3 - j1, w = 2 + j4
    localparam logic [31:0] V2_AR = 32'h40400000, V2_AI = 32'hBF800000;
    localparam logic [31:0] V2_WR = 32'h40000000, V2_WI = 32'h40800000;
    localparam logic [31:0] V2_RR = 32'h40C00000, V2_II = 32'hC0800000;
    localparam logic [31:0] V2_RI = 32'h41400000, V2_IR = 32'hC0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err, mul_str;
    logic [31:0] a_re = '0, a_im = '0, w_re = '0, w_im = '0;
    logic [31:0] p_rr, p_ii, p_ri, p_ir, mul_a, mul_b;
    logic [31:0] mul_result = '0;
    logic        mul_done = 1'b0;
    logic        mul_error = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    cmul_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .a_re       (a_re),
        .a_im       (a_im),
        .w_re       (w_re),
        .w_im       (w_im),
        .p_rr       (p_rr),
        .p_ii       (p_ii),
        .p_ri       (p_ri),
        .p_ir       (p_ir),
        .err        (err),
        .mul_str    (mul_str),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .mul_error  (mul_error)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- multiplier responder ----------------
    int   resp_req_n = 0;
    int   resp_rise_cyc = 0;
    logic resp_prev_str = 1'b0;
    int   req_base = 0;
    int   err_req = 0;
    bit   resp_silent = 1'b0;

    function automatic logic [31:0] fmul_lookup(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            {V1_AR, V1_WR}: return V1_RR;
            {V1_AI, V1_WI}: return V1_II;
            {V1_AR, V1_WI}: return V1_RI;
            {V1_AI, V1_WR}: return V1_IR;
            {V2_AR, V2_WR}: return V2_RR;
            {V2_AI, V2_WI}: return V2_II;
            {V2_AR, V2_WI}: return V2_RI;
            {V2_AI, V2_WR}: return V2_IR;
            default:        return 32'hDEADBEEF;
        endcase
    endfunction

    // mul_done is presented so the DUT samples it D edges after the edge that raised mul_str.
    always @(negedge clk) begin
        mul_done  = 1'b0;
        mul_error = 1'b0;
        if (mul_str === 1'b1 && resp_prev_str !== 1'b1) begin
            resp_req_n    = resp_req_n + 1;
            resp_rise_cyc = cyc;
        end
        if (mul_str === 1'b1 && !resp_silent && cyc == resp_rise_cyc + RESP_D - 1) begin
            mul_done   = 1'b1;
            mul_result = fmul_lookup(mul_a, mul_b);
            mul_error  = ((resp_req_n - req_base) == err_req);
        end
        resp_prev_str = mul_str;
    end

    // ---------------- gap / operand-stability monitor ----------------
    int          gaps_seen = 0, gap_bad = 0, stab_bad = 0, low_run = 0;
    bit          meas = 1'b0;
    logic        mon_prev_str = 1'b0;
    logic [31:0] mon_prev_a = '0, mon_prev_b = '0;

    always @(negedge clk) begin
        if (busy !== 1'b1) meas = 1'b0;
        if (mul_str === 1'b1) begin
            if (mon_prev_str !== 1'b1 && meas) begin
                gaps_seen = gaps_seen + 1;
                if (low_run != GAP) gap_bad = gap_bad + 1;
            end
            if (mon_prev_str === 1'b1 && (mul_a !== mon_prev_a || mul_b !== mon_prev_b))
                stab_bad = stab_bad + 1;
            meas = 1'b0;
        end else if (mon_prev_str === 1'b1 && busy === 1'b1) begin
            meas    = 1'b1;
            low_run = 1;
        end else if (meas) begin
            low_run = low_run + 1;
        end
        mon_prev_str = mul_str;
        mon_prev_a   = mul_a;
        mon_prev_b   = mul_b;
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [31:0] ar, input logic [31:0] ai,
                            input logic [31:0] wr, input logic [31:0] wi, output int s);
        @(negedge clk);
        a_re = ar; a_im = ai; w_re = wr; w_im = wi;
        req_base = resp_req_n;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int s, output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) begin
                ok  = 1'b1;
                lat = cyc - s;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_req(input int n);
        for (int i = 0; i < 200; i++) begin
            if ((resp_req_n - req_base) == n && mul_str === 1'b1) break;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (mul_str !== 1'b0) begin errors++; $display("FAIL reset_mul_str: got %b want 0", mul_str); end
        checks++; if ({mul_a, mul_b} !== 64'h0) begin errors++; $display("FAIL reset_mul_ops: got %h want 0", {mul_a, mul_b}); end
        checks++; if ({p_rr, p_ii, p_ri, p_ir} !== 128'h0) begin errors++; $display("FAIL reset_p: got %h want 0", {p_rr, p_ii, p_ri, p_ir}); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (mul_str !== 1'b0) begin errors++; $display("FAIL reset_release_str: got %b want 0", mul_str); end
    endtask

    task automatic test_normal;
        int s, lat, g0, gb0, sb0;
        bit ok;
        g0 = gaps_seen; gb0 = gap_bad; sb0 = stab_bad;
        err_req = 0;
        start_op(V1_AR, V1_AI, V1_WR, V1_WI, s);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL normal_busy_set: got %b want 1", busy); end
        checks++; if (mul_str !== 1'b1) begin errors++; $display("FAIL normal_first_str: got %b want 1", mul_str); end
        checks++; if (mul_a !== V1_AR || mul_b !== V1_WR) begin errors++; $display("FAIL normal_first_ops: got %h %h want %h %h", mul_a, mul_b, V1_AR, V1_WR); end
        wait_done(s, lat, ok);
        checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL normal_latency: got %0d want %0d", lat, LAT); end
        checks++; if (p_rr !== V1_RR) begin errors++; $display("FAIL normal_p_rr: got %h want %h", p_rr, V1_RR); end
        checks++; if (p_ii !== V1_II) begin errors++; $display("FAIL normal_p_ii: got %h want %h", p_ii, V1_II); end
        checks++; if (p_ri !== V1_RI) begin errors++; $display("FAIL normal_p_ri: got %h want %h", p_ri, V1_RI); end
        checks++; if (p_ir !== V1_IR) begin errors++; $display("FAIL normal_p_ir: got %h want %h", p_ir, V1_IR); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL normal_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_busy_clear: got %b want 0", busy); end
        checks++; if (gaps_seen - g0 != 3) begin errors++; $display("FAIL normal_gap_count: got %0d want 3", gaps_seen - g0); end
        checks++; if (gap_bad - gb0 != 0) begin errors++; $display("FAIL normal_gap_len: got %0d bad gaps want 0", gap_bad - gb0); end
        checks++; if (stab_bad - sb0 != 0) begin errors++; $display("FAIL normal_op_stable: got %0d changes want 0", stab_bad - sb0); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL normal_done_pulse: got %b want 0", done); end
        checks++; if (p_ir !== V1_IR) begin errors++; $display("FAIL normal_p_hold: got %h want %h", p_ir, V1_IR); end
    endtask

    task automatic test_second_vector;
        int s, lat;
        bit ok;
        start_op(V2_AR, V2_AI, V2_WR, V2_WI, s);
        checks++; if ({p_rr, p_ii, p_ri, p_ir} !== 128'h0) begin errors++; $display("FAIL vec2_p_cleared: got %h want 0", {p_rr, p_ii, p_ri, p_ir}); end
        wait_done(s, lat, ok);
        checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL vec2_latency: got %0d want %0d", lat, LAT); end
        checks++; if ({p_rr, p_ii, p_ri, p_ir} !== {V2_RR, V2_II, V2_RI, V2_IR}) begin errors++; $display("FAIL vec2_products: got %h want %h", {p_rr, p_ii, p_ri, p_ir}, {V2_RR, V2_II, V2_RI, V2_IR}); end
    endtask

    task automatic test_busy_reject;
        int s, lat;
        bit ok;
        start_op(V1_AR, V1_AI, V1_WR, V1_WI, s);
        wait_req(2);
        checks++; if (busy !== 1'b1 || mul_a !== V1_AI) begin errors++; $display("FAIL busy_second_req: got busy=%b mul_a=%h want 1 %h", busy, mul_a, V1_AI); end
        a_re = V2_AR; a_im = V2_AI; w_re = V2_WR; w_im = V2_WI;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(s, lat, ok);
        checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL busy_latency: got %0d want %0d", lat, LAT); end
        checks++; if ({p_rr, p_ii, p_ri, p_ir} !== {V1_RR, V1_II, V1_RI, V1_IR}) begin errors++; $display("FAIL busy_products: got %h want %h", {p_rr, p_ii, p_ri, p_ir}, {V1_RR, V1_II, V1_RI, V1_IR}); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart: got %b want 0", busy); end
    endtask

    task automatic test_mul_error;
        int s, lat;
        bit ok;
        err_req = 3;
        start_op(V1_AR, V1_AI, V1_WR, V1_WI, s);
        wait_req(3);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL error_before_third: got %b want 0", err); end
        wait_done(s, lat, ok);
        checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b want 1", err); end
        checks++; if (p_ri !== V1_RI) begin errors++; $display("FAIL error_p_ri: got %h want %h", p_ri, V1_RI); end
        err_req = 0;
        start_op(V2_AR, V2_AI, V2_WR, V2_WI, s);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL error_cleared_on_start: got %b want 0", err); end
        wait_done(s, lat, ok);
        checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL error_next_op: got %b want 0", err); end
        checks++; if (p_ii !== V2_II) begin errors++; $display("FAIL error_next_p_ii: got %h want %h", p_ii, V2_II); end
    endtask

    task automatic test_reset_mid;
        int s, lat;
        bit ok;
        start_op(V1_AR, V1_AI, V1_WR, V1_WI, s);
        wait_req(2);
        checks++; if (p_rr !== V1_RR) begin errors++; $display("FAIL midrst_pre_p_rr: got %h want %h", p_rr, V1_RR); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (mul_str !== 1'b0) begin errors++; $display("FAIL midrst_str: got %b want 0", mul_str); end
        checks++; if ({p_rr, p_ii, p_ri, p_ir} !== 128'h0) begin errors++; $display("FAIL midrst_p: got %h want 0", {p_rr, p_ii, p_ri, p_ir}); end
        @(negedge clk);
        checks++; if (mul_str !== 1'b0) begin errors++; $display("FAIL midrst_release_str: got %b want 0", mul_str); end
        start_op(V2_AR, V2_AI, V2_WR, V2_WI, s);
        wait_done(s, lat, ok);
        checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", lat, LAT); end
        checks++; if ({p_rr, p_ii, p_ri, p_ir} !== {V2_RR, V2_II, V2_RI, V2_IR}) begin errors++; $display("FAIL midrst_products: got %h want %h", {p_rr, p_ii, p_ri, p_ir}, {V2_RR, V2_II, V2_RI, V2_IR}); end
    endtask

`ifdef CMUL_SEQUENCER_TIMEOUT_EN
    task automatic test_timeout;
        int s, lat;
        bit ok;
        resp_silent = 1'b1;
        start_op(V1_AR, V1_AI, V1_WR, V1_WI, s);
        wait_done(s, lat, ok);
        checks++; if (!ok || lat != 1 + TMO + 1) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", lat, 1 + TMO + 1); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
        checks++; if ({p_rr, p_ii, p_ri, p_ir} !== 128'h0) begin errors++; $display("FAIL timeout_p: got %h want 0", {p_rr, p_ii, p_ri, p_ir}); end
        checks++; if (mul_str !== 1'b0) begin errors++; $display("FAIL timeout_str: got %b want 0", mul_str); end
        resp_silent = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_second_vector();
        test_busy_reject();
        test_mul_error();
        test_reset_mid();
`ifdef CMUL_SEQUENCER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
